// File: rtl/chan_cnt_pkg.sv
// rtl/chan_cnt_pkg.sv - shared defaults and channel-mode encoding for chan_counter
package chan_cnt_pkg;

  localparam int DEF_N_CH  = 3;
  localparam int DEF_CNT_W = 4;

  typedef enum logic {
    HOLD = 1'b0,
    WRAP = 1'b1
  } chan_mode_e;

endpackage

// File: rtl/chan_cnt_slice.sv
// rtl/chan_cnt_slice.sv - one independent counter channel with terminal count, hit and done
// dir_i is tied low by the top unless CHAN_CNT_DOWN_EN is defined.
module chan_cnt_slice
  import chan_cnt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             wrap_i,
  input  logic             dir_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic [CNT_W-1:0] val_o,
  output logic             hit_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] val_q, val_d;
  logic [CNT_W-1:0] term, start;
  logic             done_q, done_d;
  logic             at_term;
  chan_mode_e       mode;

  // A down-counting channel swaps roles: it starts from tc and terminates at zero.
  always_comb begin
    term    = dir_i ? '0 : tc_i;
    start   = dir_i ? tc_i : '0;
    mode    = chan_mode_e'(wrap_i);
    at_term = (val_q == term);
    val_d   = val_q;
    done_d  = 1'b0;
    if (clr_i) begin
      val_d = start;
    end else if (en_i) begin
      if (at_term) begin
        val_d = (mode == WRAP) ? start : val_q;
      end else begin
        val_d = dir_i ? (val_q - ONE) : (val_q + ONE);
      end
      // A hold-mode channel parked at its terminal must not re-pulse.
      done_d = (val_d == term) && (!at_term || mode == WRAP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      done_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      done_q <= done_d;
    end
  end

  assign val_o  = val_q;
  assign hit_o  = (val_q == term);
  assign done_o = done_q;

endmodule

// File: rtl/chan_counter.sv
// rtl/chan_counter.sv - N_CH independent terminal-count counters
// Optional down-count direction per channel via macro CHAN_CNT_DOWN_EN.
module chan_counter
  import chan_cnt_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CHAN_CNT_DOWN_EN
  input  logic [N_CH-1:0]       cnt_dir,
`endif
  input  logic [N_CH-1:0]       cnt_en,
  input  logic [N_CH-1:0]       cnt_clr,
  input  logic [N_CH-1:0]       cnt_wrap,
  input  logic [N_CH*CNT_W-1:0] cnt_tc,
  output logic [N_CH*CNT_W-1:0] cnt_val,
  output logic [N_CH-1:0]       cnt_hit,
  output logic [N_CH-1:0]       cnt_done
);

  logic [N_CH-1:0] dir;

`ifdef CHAN_CNT_DOWN_EN
  assign dir = cnt_dir;
`else
  assign dir = '0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    chan_cnt_slice #(
      .CNT_W(CNT_W)
    ) u_slice (
      .clk   (clk),
      .rst_n (rst),
      .en_i  (cnt_en[i]),
      .clr_i (cnt_clr[i]),
      .wrap_i(cnt_wrap[i]),
      .dir_i (dir[i]),
      .tc_i  (cnt_tc[i*CNT_W +: CNT_W]),
      .val_o (cnt_val[i*CNT_W +: CNT_W]),
      .hit_o (cnt_hit[i]),
      .done_o(cnt_done[i])
    );
  end

endmodule

// File: tb/tb_chan_counter.sv
// tb/tb_chan_counter.sv - directed self-checking bench for chan_counter (N_CH=3, CNT_W=4)
module tb_chan_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cnt_en, cnt_clr, cnt_wrap, cnt_dir;
  logic [11:0] cnt_tc;
  logic [11:0] cnt_val;
  logic [2:0]  cnt_hit, cnt_done;
  int          n_cmp = 0;
  int          n_bad = 0;

  chan_counter #(.N_CH(3), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef CHAN_CNT_DOWN_EN
    .cnt_dir (cnt_dir),
`endif
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .cnt_wrap(cnt_wrap),
    .cnt_tc  (cnt_tc),
    .cnt_val (cnt_val),
    .cnt_hit (cnt_hit),
    .cnt_done(cnt_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] val_of(input int ch);
    return cnt_val[ch*4 +: 4];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    cnt_en  = '0;
    cnt_clr = '1;
    step();
    cnt_clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cnt_en = '0; cnt_clr = '0; cnt_wrap = '0; cnt_dir = '0;
    cnt_tc = {4'd15, 4'd3, 4'd5};
    #2;
    n_cmp++;
    if (cnt_val !== 12'h000) begin n_bad++; $display("FAIL reset_val got=%h exp=000", cnt_val); end
    n_cmp++;
    if (cnt_done !== 3'b000) begin n_bad++; $display("FAIL reset_done got=%b exp=000", cnt_done); end
    n_cmp++;
    if (cnt_hit !== 3'b000) begin n_bad++; $display("FAIL reset_hit got=%b exp=000", cnt_hit); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_hold();
    logic [3:0] ev;
    clear_all();
    cnt_tc[3:0] = 4'd5; cnt_wrap[0] = 1'b0; cnt_en = 3'b001;
    for (int k = 1; k <= 8; k++) begin
      step();
      ev = (k < 5) ? 4'(k) : 4'd5;
      n_cmp++;
      if (val_of(0) !== ev) begin n_bad++; $display("FAIL hold_val k=%0d got=%0d exp=%0d", k, val_of(0), ev); end
      n_cmp++;
      if (cnt_done[0] !== (k == 5)) begin n_bad++; $display("FAIL hold_done k=%0d got=%b exp=%b", k, cnt_done[0], k == 5); end
      n_cmp++;
      if (cnt_hit[0] !== (k >= 5)) begin n_bad++; $display("FAIL hold_hit k=%0d got=%b exp=%b", k, cnt_hit[0], k >= 5); end
    end
    cnt_en = '0;
  endtask

  task automatic test_wrap();
    logic [3:0] ev;
    cnt_tc[7:4] = 4'd3; cnt_wrap[1] = 1'b1; cnt_en = 3'b010;
    for (int k = 1; k <= 8; k++) begin
      step();
      ev = 4'(k % 4);
      n_cmp++;
      if (val_of(1) !== ev) begin n_bad++; $display("FAIL wrap_val k=%0d got=%0d exp=%0d", k, val_of(1), ev); end
      n_cmp++;
      if (cnt_done !== {1'b0, ev == 4'd3, 1'b0}) begin n_bad++; $display("FAIL wrap_done k=%0d got=%b", k, cnt_done); end
      n_cmp++;
      if (val_of(0) !== 4'd5) begin n_bad++; $display("FAIL wrap_ch0_iso k=%0d got=%0d exp=5", k, val_of(0)); end
    end
    cnt_en = '0;
  endtask

  task automatic test_tc_change();
    logic [3:0] ev;
    cnt_tc[11:8] = 4'd15; cnt_wrap[2] = 1'b1; cnt_en = 3'b100;
    for (int k = 1; k <= 16; k++) begin
      step();
      ev = 4'(k % 16);
      n_cmp++;
      if (val_of(2) !== ev || cnt_done[2] !== (k == 15)) begin
        n_bad++; $display("FAIL tc15 k=%0d got=%0d/%b exp=%0d/%b", k, val_of(2), cnt_done[2], ev, k == 15);
      end
    end
    cnt_tc[11:8] = 4'd9;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_cmp++;
      if (val_of(2) !== 4'(k) || cnt_done[2] !== 1'b0) begin
        n_bad++; $display("FAIL tc9 k=%0d got=%0d/%b exp=%0d/0", k, val_of(2), cnt_done[2], k);
      end
    end
    cnt_tc[11:8] = 4'd4;
    for (int k = 1; k <= 13; k++) begin
      step();
      ev = 4'((7 + k) % 16);
      n_cmp++;
      if (val_of(2) !== ev || cnt_done[2] !== (ev == 4'd4)) begin
        n_bad++; $display("FAIL tc_lower k=%0d got=%0d/%b exp=%0d/%b", k, val_of(2), cnt_done[2], ev, ev == 4'd4);
      end
    end
    cnt_en = '0;
  endtask

  task automatic test_clr_priority();
    clear_all();
    cnt_tc = {4'd9, 4'd3, 4'd5}; cnt_wrap = 3'b111; cnt_en = 3'b111;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if (cnt_val !== {4'(k), 4'(k % 4), 4'(k)} || cnt_done !== {1'b0, k == 3, 1'b0}) begin
        n_bad++; $display("FAIL multi_run k=%0d got=%h/%b", k, cnt_val, cnt_done);
      end
    end
    cnt_clr = 3'b001;
    step();
    n_cmp++;
    if (cnt_val !== 12'h510) begin n_bad++; $display("FAIL clr_en_val got=%h exp=510", cnt_val); end
    n_cmp++;
    if (cnt_done !== 3'b000) begin n_bad++; $display("FAIL clr_en_done got=%b exp=000", cnt_done); end
    cnt_clr = '0;
    step();
    n_cmp++;
    if (cnt_val !== 12'h621) begin n_bad++; $display("FAIL after_clr got=%h exp=621", cnt_val); end
    cnt_en = '0;
  endtask

  task automatic test_tc_zero();
    clear_all();
    cnt_tc[7:4] = 4'd0; cnt_wrap[1] = 1'b1; cnt_en = 3'b010;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if (val_of(1) !== 4'd0 || cnt_done !== 3'b010 || cnt_hit[1] !== 1'b1) begin
        n_bad++; $display("FAIL tc_zero k=%0d got=%0d/%b/%b exp=0/010/1", k, val_of(1), cnt_done, cnt_hit[1]);
      end
    end
    cnt_en = '0;
  endtask

  task automatic test_async_reset();
    clear_all();
    cnt_tc[3:0] = 4'd3; cnt_wrap[0] = 1'b1; cnt_en = 3'b001;
    step(); step(); step();
    n_cmp++;
    if (val_of(0) !== 4'd3 || cnt_done !== 3'b001) begin
      n_bad++; $display("FAIL pre_rst got=%0d/%b exp=3/001", val_of(0), cnt_done);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (cnt_val !== 12'h000 || cnt_done !== 3'b000) begin
      n_bad++; $display("FAIL async_rst got=%h/%b exp=000/000", cnt_val, cnt_done);
    end
    #2 rst = 1'b1;
    step();
    n_cmp++;
    if (cnt_val !== 12'h001) begin n_bad++; $display("FAIL post_rst got=%h exp=001", cnt_val); end
    cnt_en = '0;
  endtask

`ifdef CHAN_CNT_DOWN_EN
  task automatic test_down();
    logic [3:0] seq_v [11];
    logic       seq_d [11];
    seq_v = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
    seq_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cnt_dir = 3'b001; cnt_tc[3:0] = 4'd4; cnt_wrap[0] = 1'b1;
    cnt_en = '0; cnt_clr = 3'b001;
    step();
    cnt_clr = '0;
    n_cmp++;
    if (val_of(0) !== 4'd4) begin n_bad++; $display("FAIL down_clr got=%0d exp=4", val_of(0)); end
    cnt_en = 3'b001;
    for (int k = 0; k < 11; k++) begin
      if (k == 6) cnt_wrap[0] = 1'b0;
      step();
      n_cmp++;
      if (val_of(0) !== seq_v[k] || cnt_done[0] !== seq_d[k] || cnt_hit[0] !== (seq_v[k] == 4'd0)) begin
        n_bad++; $display("FAIL down k=%0d got=%0d/%b exp=%0d/%b", k, val_of(0), cnt_done[0], seq_v[k], seq_d[k]);
      end
    end
    cnt_en = '0; cnt_dir = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_hold();
    test_wrap();
    test_tc_change();
    test_clr_priority();
    test_tc_zero();
    test_async_reset();
`ifdef CHAN_CNT_DOWN_EN
    test_down();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
